// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns and counter-width helper for the scan driver
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] DIG_0 = 7'h40;
  localparam logic [6:0] DIG_1 = 7'h79;
  localparam logic [6:0] DIG_2 = 7'h24;
  localparam logic [6:0] DIG_3 = 7'h30;
  localparam logic [6:0] DIG_4 = 7'h19;
  localparam logic [6:0] DIG_5 = 7'h12;
  localparam logic [6:0] DIG_6 = 7'h03;
  localparam logic [6:0] DIG_7 = 7'h78;
  localparam logic [6:0] DIG_8 = 7'h00;
  localparam logic [6:0] DIG_9 = 7'h18;

  // Width of a counter that holds 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - 4-bit code to active-low 7-segment pattern
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = DIG_0;
      4'd1:    seg = DIG_1;
      4'd2:    seg = DIG_2;
      4'd3:    seg = DIG_3;
      4'd4:    seg = DIG_4;
      4'd5:    seg = DIG_5;
      4'd6:    seg = DIG_6;
      4'd7:    seg = DIG_7;
      4'd8:    seg = DIG_8;
      4'd9:    seg = DIG_9;
      4'd15:   seg = SEG_MINUS;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit common-anode 7-segment driver
// with leading-zero blanking, per-digit blink and an inter-digit guard interval.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_SLOTS  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              a_to_g,
  output logic                    dp
);

  localparam int DIV_W = cnt_width(REFRESH_DIV);
  localparam int IDX_W = cnt_width(NUM_DIGITS);
  localparam int BLK_W = cnt_width(BLINK_SLOTS);

  logic [4*NUM_DIGITS-1:0] bcd_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blink_sh;
  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_above;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              glyph;
  logic                    suppressed;
  logic                    slot_end;
  logic                    guard;

  // A digit is a leading zero only if it and every more significant digit are zero.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (bcd_sh[4*i +: 4] == 4'd0);
      lz_blank[i] = blank_lz & zero_above & (i != 0);
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_code  = bcd_sh[4*i +: 4];
        cur_dp    = dp_sh[i];
        cur_blink = blink_sh[i];
        cur_lz    = lz_blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  seg7_glyph_rom u_glyph (
    .code (cur_code),
    .seg  (glyph)
  );

  assign suppressed = (cur_blink & blink_phase) | cur_lz;
  assign slot_end   = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign guard      = (div_cnt < DIV_W'(GUARD_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_sh      <= '0;
      dp_sh       <= '0;
      blink_sh    <= '0;
      div_cnt     <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= '1;
      a_to_g      <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      if (load) begin
        bcd_sh   <= bcd_in;
        dp_sh    <= dp_in;
        blink_sh <= blink_en;
      end

      if (slot_end) begin
        div_cnt   <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        if (blink_cnt == BLK_W'(BLINK_SLOTS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // Outputs reflect this cycle's counters and shadow contents.
      if (guard) begin
        an     <= '1;
        a_to_g <= SEG_BLANK;
        dp     <= 1'b1;
      end else begin
        an     <= an_sel;
        a_to_g <= suppressed ? SEG_BLANK : glyph;
        dp     <= suppressed ? 1'b1 : ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver with a cycle-level reference model
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int BLINK = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*N-1:0] bcd_in;
  logic [N-1:0]  dp_in;
  logic          load;
  logic          blank_lz;
  logic [N-1:0]  blink_en;
  logic [N-1:0]  an;
  logic [6:0]    a_to_g;
  logic          dp;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_q[$];

  // Reference model state
  int          m_div, m_idx, m_bcnt;
  logic        m_phase;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp, m_blink;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD), .BLINK_SLOTS(BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .an(an), .a_to_g(a_to_g), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h03;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h18;  4'd15: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] model_out();
    logic       sup, lz;
    logic [15:0] upper;
    logic [3:0] code;
    logic [3:0] an_e;
    if (m_div < GUARD) return {4'hF, 7'h7F, 1'b1};
    upper = m_bcd >> (4 * m_idx);
    code  = upper[3:0];
    lz    = blank_lz && (m_idx > 0) && (upper == 16'h0);
    sup   = (m_blink[m_idx] & m_phase) | lz;
    an_e  = ~(4'b0001 << m_idx);
    return {an_e, sup ? 7'h7F : ref_glyph(code), sup ? 1'b1 : ~m_dp[m_idx]};
  endfunction

  task automatic model_reset();
    m_div = 0; m_idx = 0; m_bcnt = 0; m_phase = 1'b0;
    m_bcd = '0; m_dp = '0; m_blink = '0;
  endtask

  task automatic model_step();
    if (load) begin
      m_bcd = bcd_in; m_dp = dp_in; m_blink = blink_en;
    end
    if (m_div == DIV - 1) begin
      m_div = 0;
      m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      if (m_bcnt == BLINK - 1) begin
        m_bcnt = 0; m_phase = ~m_phase;
      end else m_bcnt = m_bcnt + 1;
    end else m_div = m_div + 1;
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
             tag, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
    end
  endtask

  // One clock: push the model's prediction, advance the model, then compare after the edge.
  task automatic tick(input string tag);
    logic [11:0] want;
    exp_q.push_back(model_out());
    model_step();
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(tag, {an, a_to_g, dp}, want);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] bl);
    bcd_in = b; dp_in = d; blink_en = bl; load = 1'b1;
    tick("load");
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bcd_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0; blink_en = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {an, a_to_g, dp}, {4'hF, 7'h7F, 1'b1});
    rst_n = 1'b1;

    // 1: guard cycle first, then digit 0
    tick("post_reset_guard");
    check("guard_blank", {an, a_to_g, dp}, {4'hF, 7'h7F, 1'b1});
    tick("first_lit");
    check("first_slot_an", {8'h0, an}, {8'h0, 4'hE});

    // 2: plain digits with one decimal point
    do_load(16'h1234, 4'b0100, 4'b0000);
    for (int k = 0; k < 2 * N * DIV; k++) begin
      tick("digits_1234");
      if (an == 4'hB) check("dp_digit2", {an, a_to_g, dp}, {4'hB, 7'h24, 1'b0});
    end

    // 3: leading-zero blanking on and off
    blank_lz = 1'b1;
    do_load(16'h0007, 4'b1110, 4'b0000);
    run("lz_0007", N * DIV + 2);
    blank_lz = 1'b0;
    run("no_lz_0007", N * DIV);

    // 4: minus sign makes the zeros below it significant
    blank_lz = 1'b1;
    do_load(16'hF005, 4'b0000, 4'b0000);
    run("lz_F005", 2 * N * DIV);
    blank_lz = 1'b0;

    // 5: blink on digit 0 across several phase toggles
    do_load(16'h5678, 4'b0001, 4'b0001);
    run("blink", 6 * N * DIV);

    // 6: asynchronous reset in the middle of the digit-2 slot
    do_load(16'h9999, 4'b1111, 4'b0000);
    for (int k = 0; k < 64 && !(m_idx == 2 && m_div == 2); k++) tick("to_digit2");
    check("reached_digit2", {8'h0, an}, {8'h0, 4'hB});
    rst_n = 1'b0;
    #1;
    check("async_blank", {an, a_to_g, dp}, {4'hF, 7'h7F, 1'b1});
    @(posedge clk);
    #1;
    check("held_blank", {an, a_to_g, dp}, {4'hF, 7'h7F, 1'b1});
    rst_n = 1'b1;
    model_reset();
    tick("restart_guard");
    tick("restart_digit0");
    check("restart_zero", {an, a_to_g, dp}, {4'hE, 7'h40, 1'b1});
    run("restart_scan", N * DIV);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
